// File: rtl/alu_serial_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// alu_serial_ctrl: bit-serial LSB-first ALU built around a single alu1 slice.
// Define ALU_SERIAL_SUB_EN to enable op 3'b010 (A - B); otherwise that op is reserved.

module alu1 (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [2:0] op_i,
  output logic       y_o,
  output logic       cout_o
);
  always_comb begin
    y_o    = 1'b0;
    cout_o = 1'b0;
    case (op_i)
      3'b111: y_o = a_i & b_i;
      3'b110: y_o = ~a_i;
      3'b101: y_o = a_i | b_i;
      3'b100: y_o = a_i ^ b_i;
      3'b011: begin
        y_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
      end
      default: begin
        y_o    = 1'b0;
        cout_o = 1'b0;
      end
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q;

  logic       slice_b_d, slice_cin_d, slice_y_d, slice_cout_d, carry_init_d;
  logic [2:0] slice_op_d;

`ifdef ALU_SERIAL_SUB_EN
  logic sub_d;
  // Subtraction reuses the adder: invert B per bit and seed the carry with 1.
  assign sub_d        = (op_q == 3'b010);
  assign slice_op_d   = sub_d ? 3'b011 : op_q;
  assign slice_b_d    = b_q[0] ^ sub_d;
  assign carry_init_d = (op == 3'b010);
`else
  assign slice_op_d   = op_q;
  assign slice_b_d    = b_q[0];
  assign carry_init_d = 1'b0;
`endif

  // Logic ops never see the carry flop, so no carry state leaks between operations.
  assign slice_cin_d = (slice_op_d == 3'b011) & carry_q;

  alu1 u_slice (
    .a_i    (a_q[0]),
    .b_i    (slice_b_d),
    .cin_i  (slice_cin_d),
    .op_i   (slice_op_d),
    .y_o    (slice_y_d),
    .cout_o (slice_cout_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'b000;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            cnt_q   <= '0;
            carry_q <= carry_init_d;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          result_q <= {slice_y_d, result_q[WIDTH-1:1]};
          carry_q  <= slice_cout_d;
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            cout_q  <= slice_cout_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// tb_alu_serial_ctrl: directed scoreboard bench for alu_serial_ctrl at WIDTH=4.
// Honours ALU_SERIAL_SUB_EN the same way as the design build.

module tb_alu_serial_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       busy, done, carry_out;
  logic [3:0] result;

  typedef struct {
    logic [3:0] r;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  alu_serial_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ":sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ":result"}, {4'h0, result}, {4'h0, e.r});
      chk({tag, ":carry"}, {7'd0, carry_out}, {7'd0, e.c});
    end
  endtask

  // One operation: start for one edge (optionally re-poked during RUN), exact-latency checks.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] xa,
                        input logic [3:0] xb, input logic [3:0] er, input logic ec,
                        input bit poke);
    exp_t e;
    int   d0;
    op = o; a = xa; b = xb; start = 1'b1;
    e.r = er; e.c = ec;
    sb.push_back(e);
    d0 = done_cnt;
    tick();
    a = ~xa; b = ~xb; op = ~o;
    chk({tag, ":busy_k"}, {7'd0, busy}, 8'd1);
    chk({tag, ":done_k"}, {7'd0, done}, 8'd0);
    for (int i = 1; i < 4; i++) begin
      start = poke && (i <= 2);
      if (poke) begin a = 4'h3; b = 4'h3; op = 3'b011; end
      tick();
      chk({tag, ":busy_run"}, {7'd0, busy}, 8'd1);
      chk({tag, ":done_run"}, {7'd0, done}, 8'd0);
    end
    start = 1'b0;
    tick();
    chk({tag, ":done_pulse"}, {7'd0, done}, 8'd1);
    chk({tag, ":busy_done"}, {7'd0, busy}, 8'd0);
    pop_cmp(tag);
    tick();
    chk({tag, ":done_low"}, {7'd0, done}, 8'd0);
    chk({tag, ":hold"}, {4'h0, result}, {4'h0, er});
    chk({tag, ":done_count"}, 8'(done_cnt - d0), 8'd1);
  endtask

  initial begin
    int   d0;
    exp_t e;

    #2;
    chk("reset:busy", {7'd0, busy}, 8'd0);
    chk("reset:done", {7'd0, done}, 8'd0);
    chk("reset:result", {4'h0, result}, 8'h00);
    chk("reset:carry", {7'd0, carry_out}, 8'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op("add_7_9", 3'b011, 4'h7, 4'h9, 4'h0, 1'b1, 1'b0);
    run_op("and", 3'b111, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0);
    run_op("or", 3'b101, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0);
    run_op("xor", 3'b100, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0);
    run_op("not", 3'b110, 4'hC, 4'hA, 4'h3, 1'b0, 1'b0);
    run_op("add_f_1", 3'b011, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0);
    run_op("add_3_4", 3'b011, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0);
    run_op("rsv_000", 3'b000, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    run_op("rsv_001", 3'b001, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
`ifdef ALU_SERIAL_SUB_EN
    run_op("sub_3_5", 3'b010, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0);
    run_op("sub_5_3", 3'b010, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0);
`else
    run_op("rsv_010", 3'b010, 4'h3, 4'h5, 4'h0, 1'b0, 1'b0);
    run_op("rsv_010b", 3'b010, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0);
`endif
    run_op("poke_ignored", 3'b011, 4'h7, 4'h9, 4'h0, 1'b1, 1'b1);
    tick(); tick();
    chk("poke:idle_busy", {7'd0, busy}, 8'd0);

    // Abort in the middle of bit 2, reset asserted between clock edges.
    op = 3'b011; a = 4'h7; b = 4'h9; start = 1'b1;
    e.r = 4'h0; e.c = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
    tick(); tick();
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("abort:busy", {7'd0, busy}, 8'd0);
    chk("abort:done", {7'd0, done}, 8'd0);
    chk("abort:result", {4'h0, result}, 8'h00);
    chk("abort:carry", {7'd0, carry_out}, 8'd0);
    void'(sb.pop_back());
    #2 rst = 1'b0;
    run_op("after_abort", 3'b011, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0);
    chk("abort:no_extra_done", 8'(done_cnt - d0), 8'd1);

    // Start held high: accepts every WIDTH+2 cycles.
    op = 3'b101; a = 4'h5; b = 4'h2; start = 1'b1;
    e.r = 4'h7; e.c = 1'b0;
    for (int n = 0; n < 3; n++) sb.push_back(e);
    d0 = done_cnt;
    tick();
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c % 6 == 4) begin
        chk("b2b:done_hi", {7'd0, done}, 8'd1);
        pop_cmp("b2b");
      end else begin
        chk("b2b:done_lo", {7'd0, done}, 8'd0);
      end
      chk("b2b:busy", {7'd0, busy}, (c % 6 < 4) ? 8'd1 : 8'd0);
    end
    start = 1'b0;
    tick(); tick();
    chk("b2b:done_count", 8'(done_cnt - d0), 8'd3);
    chk("b2b:idle", {7'd0, busy}, 8'd0);
    chk("sb:drained", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
